// File: rtl/ps2_host_tx_if.sv
// Command handshake and status between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits, odd parity,
// stop, device ACK and return-to-idle check on the shared open-drain clock/data pins.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic         CLOCK_50,
  input  logic         reset_n,
  ps2_host_tx_if.slave cmd,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam int unsigned CNT_MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned EDGE_W    = 4;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_WAIT_IDLE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [7:0]          data_q, data_d;
  logic                parity_q, parity_d;

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic clk_fall;

  logic clk_oe_q, clk_oe_d;
  logic dat_oe_q, dat_oe_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;

  assign clk_fall = clk_prev & ~clk_s2;

  assign ps2_clk_oe    = clk_oe_q;
  assign ps2_dat_oe    = dat_oe_q;
  assign cmd.cmd_ready = ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.tx_done   = done_q;
  assign cmd.tx_error  = error_q;

  // State, datapath, synchronizers and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      edge_q   <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat_in;
      dat_s2   <= dat_s1;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    data_d   = data_q;
    parity_d = parity_q;
    dat_oe_d = dat_oe_q;

    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          data_d   = cmd.cmd_data;
          parity_d = ~^cmd.cmd_data;
          cnt_d    = '0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_RTS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RTS: begin
        if (cnt_q == RTS_LAST) begin
          cnt_d   = '0;
          edge_d  = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        // edge_q counts device falling edges already seen in this frame
        if (clk_fall) begin
          cnt_d  = '0;
          edge_d = edge_q + EDGE_W'(1);
          if (edge_q < EDGE_W'(8)) begin
            dat_oe_d = ~data_q[edge_q[2:0]];
          end else if (edge_q == EDGE_W'(8)) begin
            dat_oe_d = ~parity_q;
          end else if (edge_q == EDGE_W'(9)) begin
            dat_oe_d = 1'b0;
          end else begin
            state_d = dat_s2 ? S_ERROR : S_WAIT_IDLE;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2 && dat_s2) begin
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Data is only ever pulled low during request-to-send and the bit frame
    if (state_d == S_RTS) begin
      dat_oe_d = 1'b1;
    end else if (state_d != S_SHIFT) begin
      dat_oe_d = 1'b0;
    end

    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_RTS);
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERROR);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Sits beside the PS/2 receive path in the blackjack input subsystem and shares the PS2_CLK/PS2_DAT open-drain pins.
- Runs the full sequence: inhibit, request-to-send, 8 data bits, odd parity, stop, device ACK, return-to-idle check.
- Reports completion or failure with one-cycle pulses.

Parameters:
- INHIBIT_CYCLES, 5000: cycles PS2_CLK is held low before RTS (100 us at 50 MHz).
- RTS_CYCLES, 50: cycles both lines are held low before PS2_CLK is released.
- TIMEOUT_CYCLES, 100000: maximum cycles between device clock falling edges, and while waiting for bus idle (2 ms).

Ports:
- CLOCK_50, input, 1: system clock, 50 MHz.
- reset_n, input, 1: synchronous, active-low reset.
- cmd_valid, input, 1: command byte available.
- cmd_data, input, 8: command byte, sent LSB first.
- cmd_ready, output, 1: block idle; a byte is accepted when cmd_valid && cmd_ready.
- ps2_clk_in, input, 1: raw PS2_CLK pin level (asynchronous).
- ps2_dat_in, input, 1: raw PS2_DAT pin level (asynchronous).
- ps2_clk_oe, output, 1: 1 = drive PS2_CLK low, 0 = release (Z). Top level maps this to the tristate.
- ps2_dat_oe, output, 1: 1 = drive PS2_DAT low, 0 = release (Z).
- busy, output, 1: transaction in progress, i.e. state != IDLE.
- tx_done, output, 1: one-cycle pulse; byte ACKed and bus returned to idle.
- tx_error, output, 1: one-cycle pulse; NACK or timeout.

Behaviour:
- Reset (reset_n=0 at a CLOCK_50 edge):
  - State goes to IDLE; ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_error=0, busy=0, cmd_ready=1.
  - Synchronizers are set to 1.
  - Reset mid-transaction releases both lines on that same edge; no done/error pulse is produced.
- Inputs pass through a 2-flop synchronizer. A falling edge is prev_sync=1 and cur_sync=0 on the synchronized clock.
- Outputs are registered. oe=1 only ever drives low; the block never drives high.
- IDLE:
  - cmd_ready=1.
  - On accept: latch cmd_data and compute parity = ~^cmd_data (odd parity).
  - Next cycle enter INHIBIT; cmd_ready=0 from that cycle.
- INHIBIT:
  - clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
  - Clock edges during INHIBIT are ignored.
- RTS:
  - clk_oe=1, dat_oe=1 (start bit = 0) for RTS_CYCLES cycles.
  - Then enter SHIFT with clk_oe=0, dat_oe=1, bit_cnt=0, timeout counter cleared.
- SHIFT, counting device falling edges:
  - Edges 1..8 set dat_oe = ~data[bit_cnt] and increment bit_cnt.
  - Edge 9 sets dat_oe = ~parity.
  - Edge 10 sets dat_oe=0 (stop bit, line released).
  - Edge 11 samples synchronized data: 0 = ACK, go to WAIT_IDLE; 1 = NACK, go to ERROR.
- WAIT_IDLE:
  - Lines stay released; wait until synchronized clk=1 and dat=1.
  - Then one cycle with tx_done=1, and IDLE.
- Timeout:
  - The counter resets on each falling edge in SHIFT and runs continuously in WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES in SHIFT or WAIT_IDLE goes to ERROR.
- ERROR:
  - Both oe=0; one cycle with tx_error=1, then IDLE.
  - tx_done and tx_error are never asserted together.
- cmd_valid while busy is ignored; no queueing.
- A new command is accepted no earlier than the cycle after a done/error pulse.

Test Plan:
- cmd_data=0xED with a device BFM that ACKs:
  - clk_oe is low for 5000 cycles, then both lines low for 50 cycles.
  - Data bits on edges 1..8 are 1,0,1,1,0,1,1,1; parity on edge 9 is 1; data released on edge 10.
  - ACK sampled on edge 11; tx_done pulses once; busy falls with it.
- cmd_data=0xF4 → parity bit 0 on edge 9; tx_done pulses. cmd_data=0x00 → all data bits 0, parity 1.
- BFM leaves data high on edge 11 → tx_error pulses, tx_done stays 0, both oe=0, cmd_ready=1 the next cycle.
- BFM stops clocking after edge 4 → tx_error exactly TIMEOUT_CYCLES after edge 4; lines released.
- reset_n low during SHIFT (after edge 5) → clk_oe=dat_oe=0 and busy=0 at that edge; no pulses. A following 0xFF completes normally.
- cmd_valid held high across a transaction with a second byte 0x55 → the second byte is not accepted until the cycle after tx_done, then is sent intact.
